// File: rtl/m_dmem_pkg.sv
// Shared definitions for the M-stage data-memory controller.
// Memop codes, FSM states, byte-enable constants and lane helpers.
package m_dmem_pkg;

  typedef enum logic [3:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LW   = 4'd1,
    MEMOP_LH   = 4'd2,
    MEMOP_LHU  = 4'd3,
    MEMOP_LB   = 4'd4,
    MEMOP_LBU  = 4'd5,
    MEMOP_SW   = 4'd6,
    MEMOP_SH   = 4'd7,
    MEMOP_SB   = 4'd8
  } memop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  function automatic logic op_valid(logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  function automatic logic is_store(logic [3:0] op);
    return (op == MEMOP_SW) || (op == MEMOP_SH) ||
           (op == MEMOP_SB);
  endfunction

  function automatic logic is_word(logic [3:0] op);
    return (op == MEMOP_LW) || (op == MEMOP_SW);
  endfunction

  function automatic logic is_half(logic [3:0] op);
    return (op == MEMOP_LH) || (op == MEMOP_LHU) ||
           (op == MEMOP_SH);
  endfunction

  function automatic logic [3:0] byte_en(
    logic [3:0] op,
    logic [1:0] off
  );
    logic [3:0] be;
    be = BE_BYTE0 << off;
    if (is_word(op))
      be = BE_WORD;
    else if (is_half(op))
      be = off[1] ? BE_HALF_HI : BE_HALF_LO;
    return be;
  endfunction

endpackage

// File: rtl/m_dmem_ext.sv
// Load lane select plus sign/zero extension.
// Ports: op (memop), off (addr[1:0]), word (bus word) -> res.
module m_dmem_ext
  import m_dmem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] res
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b   = word[{off, 3'b000} +: 8];
    h   = off[1] ? word[31:16] : word[15:0];
    res = word;
    unique case (1'b1)
      op == MEMOP_LB:  res = {{24{b[7]}}, b};
      op == MEMOP_LBU: res = {24'b0, b};
      op == MEMOP_LH:  res = {{16{h[15]}}, h};
      op == MEMOP_LHU: res = {16'b0, h};
      default:         res = word;
    endcase
  end

endmodule

// File: rtl/m_dmem_ctrl.sv
// M-stage data-memory controller: req/ack bus, stall, load extend.
// Ports: clk, reset (sync, active-low), M_memop/M_ALUResult/M_RD2 in,
// M_RDM/M_stall/addr_exc out, bus_req/we/addr/be/wdata/err out,
// bus_ack/bus_rdata in. Option macro: M_DMEM_ALIGN_CHECK_EN.
module m_dmem_ctrl
  import m_dmem_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  M_memop,
  input  logic [31:0] M_ALUResult,
  input  logic [31:0] M_RD2,
  output logic [31:0] M_RDM,
  output logic        M_stall,
  output logic        addr_exc,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam logic [TO_W-1:0] TO_LIM =
    TO_W'(ACK_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [1:0]      off_q, off_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [31:0]     rdm_q, rdm_d;

  logic [31:0] a_al;
  logic [31:0] lanes;
  logic [31:0] ld_res;
  logic        allowed;
  logic        exc;

  m_dmem_ext u_ext (
    .op   (op_q),
    .off  (off_q),
    .word (bus_rdata),
    .res  (ld_res)
  );

  // Natural alignment; in the checked build only aligned ops get here.
  always_comb begin
    a_al = M_ALUResult;
    if (is_word(M_memop))
      a_al[1:0] = 2'b00;
    else if (is_half(M_memop))
      a_al[0] = 1'b0;
  end

  always_comb begin
    lanes = 32'b0;
    unique case (1'b1)
      M_memop == MEMOP_SB: lanes = {4{M_RD2[7:0]}};
      M_memop == MEMOP_SH: lanes = {2{M_RD2[15:0]}};
      M_memop == MEMOP_SW: lanes = M_RD2;
      default:             lanes = 32'b0;
    endcase
  end

`ifdef M_DMEM_ALIGN_CHECK_EN
  logic mis;
  always_comb begin
    mis = (is_word(M_memop) && (M_ALUResult[1:0] != 2'b00)) ||
          (is_half(M_memop) && M_ALUResult[0]);
    allowed = op_valid(M_memop) && !mis;
    exc     = op_valid(M_memop) && mis;
  end
`else
  always_comb begin
    allowed = op_valid(M_memop);
    exc     = 1'b0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    off_d    = off_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    err_d    = 1'b0;
    rdm_d    = rdm_q;
    M_stall  = 1'b0;
    addr_exc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        addr_exc = reset && exc;
        if (allowed) begin
          M_stall = 1'b1;
          state_d = ST_BUSY;
          cnt_d   = '0;
          op_d    = M_memop;
          off_d   = a_al[1:0];
          req_d   = 1'b1;
          we_d    = is_store(M_memop);
          addr_d  = {a_al[31:2], 2'b00};
          be_d    = byte_en(M_memop, a_al[1:0]);
          wdata_d = lanes;
        end
      end
      ST_BUSY: begin
        M_stall = 1'b1;
        // Ack wins over a timeout landing in the same cycle.
        if (bus_ack) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
          if (!is_store(op_q))
            rdm_d = ld_res;
        end else if (cnt_q == TO_LIM) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          rdm_d   = 32'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 4'b0;
      off_q   <= 2'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'b0;
      be_q    <= 4'b0;
      wdata_q <= 32'b0;
      err_q   <= 1'b0;
      rdm_q   <= 32'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      off_q   <= off_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdm_q   <= rdm_d;
    end
  end

  assign M_RDM     = rdm_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_m_dmem_ctrl.sv
// Self-checking bench for m_dmem_ctrl (ACK_TIMEOUT=4).
// Table vectors, hand sequences, and randomized ops vs a model.
module tb_m_dmem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  M_memop;
  logic [31:0] M_ALUResult, M_RD2, M_RDM;
  logic        M_stall, addr_exc;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  m_dmem_ctrl #(.ACK_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .M_memop(M_memop), .M_ALUResult(M_ALUResult),
    .M_RD2(M_RD2), .M_RDM(M_RDM), .M_stall(M_stall),
    .addr_exc(addr_exc), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] rd2;
    logic [31:0] rdata;
    int          ack_k;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdm;
    int          e_st;
    logic        e_err;
  } vec_t;

  int nvec = 0;
  int nmis = 0;
  logic [31:0] model_rdm = 32'h0;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model from the access rules, plain arithmetic.
  function automatic vec_t mk_vec(input logic [3:0] op,
    input logic [31:0] addr, input logic [31:0] rd2,
    input logic [31:0] rdata, input int ack_k,
    input logic [31:0] prev);
    vec_t v;
    int unsigned a, off, sz, val;
    bit sgn, st;
    sz  = (op == 1 || op == 6) ? 4 :
          (op == 2 || op == 3 || op == 7) ? 2 : 1;
    sgn = (op == 2 || op == 4);
    st  = (op >= 6);
    a   = addr - (addr % sz);
    off = a % 4;
    v.op = op; v.addr = addr; v.rd2 = rd2;
    v.rdata = rdata; v.ack_k = ack_k;
    v.e_addr = a - off;
    if (sz == 4) v.e_be = 4'hF;
    else if (sz == 2) v.e_be = (off >= 2) ? 4'hC : 4'h3;
    else v.e_be = 4'(1 << off);
    if (sz == 1) v.e_wdata = (rd2 % 256) * 32'h0101_0101;
    else if (sz == 2) v.e_wdata = (rd2 % 65536) * 32'h0001_0001;
    else v.e_wdata = rd2;
    if (sz == 4) val = rdata;
    else begin
      val = (rdata >> (8 * off)) % (1 << (8 * sz));
      if (sgn && val >= (1 << (8 * sz - 1)))
        val = val - (1 << (8 * sz));
    end
    if (ack_k < 0) v.e_rdm = 32'h0;
    else if (st) v.e_rdm = prev;
    else v.e_rdm = val;
    v.e_st  = (ack_k < 0) ? TO + 1 : ack_k + 1;
    v.e_err = (ack_k < 0);
    return v;
  endfunction

  task automatic run(input vec_t v, input string nm);
    int  st;
    bit  done;
    st = 0;
    done = 0;
    @(posedge clk); #1;
    M_memop = v.op; M_ALUResult = v.addr; M_RD2 = v.rd2;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      bus_ack   = (c == v.ack_k);
      bus_rdata = (c == v.ack_k) ? v.rdata : $urandom;
      @(negedge clk);
      if (c == 0) begin
        chk({nm, " exc"}, {31'b0, addr_exc}, 32'h0);
        chk({nm, " err0"}, {31'b0, bus_err}, 32'h0);
      end
      if (c == 1) begin
        chk({nm, " req"}, {31'b0, bus_req}, 32'h1);
        chk({nm, " addr"}, bus_addr, v.e_addr);
        chk({nm, " be"}, {28'b0, bus_be}, {28'b0, v.e_be});
        chk({nm, " we"}, {31'b0, bus_we},
            {31'b0, (v.op >= 4'd6)});
        if (v.op >= 4'd6)
          chk({nm, " wdata"}, bus_wdata, v.e_wdata);
      end
      if (M_stall) st++;
      else begin
        done = 1;
        chk({nm, " stalls"}, st, v.e_st);
        chk({nm, " rdm"}, M_RDM, v.e_rdm);
        chk({nm, " err"}, {31'b0, bus_err}, {31'b0, v.e_err});
        chk({nm, " reqdone"}, {31'b0, bus_req}, 32'h0);
      end
    end
    bus_ack = 1'b0;
    if (!done) chk({nm, " done_timeout"}, 32'h0, 32'h1);
    model_rdm = v.e_rdm;
  endtask

  initial begin
    tbl[0] = '{4'd6, 32'h104, 32'hDEADBEEF, 32'h0, 3,
               32'h104, 4'hF, 32'hDEADBEEF, 32'h0, 4, 1'b0};
    tbl[1] = '{4'd8, 32'h103, 32'h0000_00A5, 32'h0, 1,
               32'h100, 4'h8, 32'hA5A5A5A5, 32'h0, 2, 1'b0};
    tbl[2] = '{4'd4, 32'h202, 32'h0, 32'h1280_3456, 2,
               32'h200, 4'h4, 32'h0, 32'hFFFF_FF80, 3, 1'b0};
    tbl[3] = '{4'd5, 32'h202, 32'h0, 32'h1280_3456, 1,
               32'h200, 4'h4, 32'h0, 32'h0000_0080, 2, 1'b0};
    tbl[4] = '{4'd2, 32'h202, 32'h0, 32'h8001_0000, 1,
               32'h200, 4'hC, 32'h0, 32'hFFFF_8001, 2, 1'b0};
    tbl[5] = '{4'd3, 32'h200, 32'h0, 32'h8001_7FFE, 2,
               32'h200, 4'h3, 32'h0, 32'h0000_7FFE, 3, 1'b0};
    tbl[6] = '{4'd1, 32'h300, 32'h0, 32'h0, -1,
               32'h300, 4'hF, 32'h0, 32'h0, 5, 1'b1};
    tbl[7] = '{4'd1, 32'h304, 32'h0, 32'hCAFE_F00D, 4,
               32'h304, 4'hF, 32'h0, 32'hCAFE_F00D, 5, 1'b0};
    tbl[8] = '{4'd7, 32'h10A, 32'h1234_ABCD, 32'h0, 1,
               32'h108, 4'hC, 32'hABCD_ABCD, 32'hCAFE_F00D, 2, 1'b0};

    reset = 1'b0; M_memop = 4'd0; M_ALUResult = 32'h0;
    M_RD2 = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst req", {31'b0, bus_req}, 32'h0);
    chk("rst stall", {31'b0, M_stall}, 32'h0);
    chk("rst rdm", M_RDM, 32'h0);
    chk("rst be", {28'b0, bus_be}, 32'h0);
    chk("rst addr", bus_addr, 32'h0);

    for (int i = 0; i < 9; i++)
      run(tbl[i], $sformatf("tbl%0d", i));

    // Undefined opcode behaves as NONE.
    @(posedge clk); #1;
    M_memop = 4'd12; M_ALUResult = 32'h500;
    @(negedge clk);
    chk("bad stall", {31'b0, M_stall}, 32'h0);
    @(negedge clk);
    chk("bad req", {31'b0, bus_req}, 32'h0);

`ifdef M_DMEM_ALIGN_CHECK_EN
    @(posedge clk); #1;
    M_memop = 4'd1; M_ALUResult = 32'h102;
    @(negedge clk);
    chk("mis exc", {31'b0, addr_exc}, 32'h1);
    chk("mis stall", {31'b0, M_stall}, 32'h0);
    @(posedge clk); #1;
    M_memop = 4'd0;
    @(negedge clk);
    chk("mis req", {31'b0, bus_req}, 32'h0);
    chk("mis rdm", M_RDM, model_rdm);
`else
    run(mk_vec(4'd1, 32'h102, 32'h0, 32'h1122_3344, 1,
               model_rdm), "mis");
`endif

    // Reset in the middle of an access; later stray ack ignored.
    @(posedge clk); #1;
    M_memop = 4'd1; M_ALUResult = 32'h400;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; M_memop = 4'd0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mrst req", {31'b0, bus_req}, 32'h0);
    chk("mrst stall", {31'b0, M_stall}, 32'h0);
    chk("mrst rdm", M_RDM, 32'h0);
    model_rdm = 32'h0;
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("stray rdm", M_RDM, 32'h0);
    chk("stray stall", {31'b0, M_stall}, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] ad;
      int          k;
      op = 4'($urandom_range(1, 8));
      ad = $urandom;
`ifdef M_DMEM_ALIGN_CHECK_EN
      if (op == 1 || op == 6) ad[1:0] = 2'b00;
      else if (op == 2 || op == 3 || op == 7) ad[0] = 1'b0;
`endif
      k = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(1, TO);
      run(mk_vec(op, ad, $urandom, $urandom, k, model_rdm),
          $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
